// File: rtl/div_arbiter.sv
// div_arbiter: round-robin front end for the shared restoring divider.
// Grants one client at a time, holds div_start for DIV_LATENCY cycles,
// samples the quotient and returns it with a one-cycle resp_valid pulse.
// A zero divisor is answered locally with all-ones and never starts the divider.
module div_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int DIV_LATENCY = 36
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [32*NUM_REQ-1:0]    req_dividend,
    input  logic [32*NUM_REQ-1:0]    req_divisor,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       resp_valid,
    output logic [31:0]              resp_quotient,
    output logic                     busy,
    output logic                     div_start,
    output logic [31:0]              div_dividend,
    output logic [31:0]              div_divisor,
    input  logic [31:0]              div_quotient
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(DIV_LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [IDX_W-1:0]   owner_reg;
    logic [IDX_W-1:0]   last_grant_reg;
    logic [NUM_REQ-1:0] resp_valid_reg;
    logic [31:0]        resp_quotient_reg;
    logic               div_start_reg;
    logic [31:0]        div_dividend_reg;
    logic [31:0]        div_divisor_reg;

    logic [31:0]        dividend_arr [NUM_REQ];
    logic [31:0]        divisor_arr  [NUM_REQ];
    logic               grant_found;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W:0]     rr_sum;
    logic               accept;
    logic [31:0]        sel_dividend;
    logic [31:0]        sel_divisor;

    // Accept only in IDLE and never while reset is held.
    assign accept = rst_n && (state_reg == IDLE) && grant_found;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_client
            assign dividend_arr[gi] = req_dividend[32*gi +: 32];
            assign divisor_arr[gi]  = req_divisor[32*gi +: 32];
            assign req_ready[gi]    = accept && (grant_idx == IDX_W'(gi));
        end
    endgenerate

    // Rotating priority: scan from last_grant+1, wrapping modulo NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        rr_sum      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_sum = {1'b0, last_grant_reg} + (IDX_W+1)'(k);
            if (rr_sum >= (IDX_W+1)'(NUM_REQ)) begin
                rr_sum = rr_sum - (IDX_W+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid[rr_sum[IDX_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = rr_sum[IDX_W-1:0];
            end
        end
    end

    assign sel_dividend = dividend_arr[grant_idx];
    assign sel_divisor  = divisor_arr[grant_idx];

    // Sequencer: IDLE accepts, RUN holds div_start, DONE pulses resp_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            cnt_reg           <= '0;
            owner_reg         <= '0;
            last_grant_reg    <= IDX_W'(NUM_REQ-1);
            resp_valid_reg    <= '0;
            resp_quotient_reg <= '0;
            div_start_reg     <= 1'b0;
            div_dividend_reg  <= '0;
            div_divisor_reg   <= '0;
        end else begin
            resp_valid_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (grant_found) begin
                        div_dividend_reg <= sel_dividend;
                        div_divisor_reg  <= sel_divisor;
                        owner_reg        <= grant_idx;
                        last_grant_reg   <= grant_idx;
                        if (sel_divisor != 32'd0) begin
                            state_reg     <= RUN;
                            cnt_reg       <= CNT_W'(DIV_LATENCY-1);
                            div_start_reg <= 1'b1;
                        end else begin
                            resp_quotient_reg <= 32'hFFFF_FFFF;
                            resp_valid_reg    <= NUM_REQ'(1) << grant_idx;
                            state_reg         <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (cnt_reg == '0) begin
                        resp_quotient_reg <= div_quotient;
                        resp_valid_reg    <= NUM_REQ'(1) << owner_reg;
                        div_start_reg     <= 1'b0;
                        state_reg         <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg     <= IDLE;
                    div_start_reg <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = (state_reg != IDLE);
    assign resp_valid    = resp_valid_reg;
    assign resp_quotient = resp_quotient_reg;
    assign div_start     = div_start_reg;
    assign div_dividend  = div_dividend_reg;
    assign div_divisor   = div_divisor_reg;

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a latency-accurate divider model.
module tb_div_arbiter;

    localparam int NUM_REQ     = 2;
    localparam int DIV_LATENCY = 36;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   req_valid = '0;
    logic [63:0]  req_dividend = '0;
    logic [63:0]  req_divisor = '0;
    logic [1:0]   req_ready;
    logic [1:0]   resp_valid;
    logic [31:0]  resp_quotient;
    logic         busy;
    logic         div_start;
    logic [31:0]  div_dividend;
    logic [31:0]  div_divisor;
    logic [31:0]  div_quotient;

    div_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .DIV_LATENCY (DIV_LATENCY)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .req_ready     (req_ready),
        .resp_valid    (resp_valid),
        .resp_quotient (resp_quotient),
        .busy          (busy),
        .div_start     (div_start),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_quotient  (div_quotient)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Divider model: result appears only 35 cycles after the start rising edge,
    // plus a watch on the number of low cycles before every rising edge.
    logic        ds_prev = 1'b0;
    int          low_run = 2;
    int          gap_viol = 0;
    logic [31:0] m_q = '0;
    int          m_cnt = 0;

    always @(posedge clk) begin
        ds_prev <= div_start;
        if (div_start === 1'b1) begin
            low_run <= 0;
            if (!ds_prev) begin
                if (low_run < 2) gap_viol <= gap_viol + 1;
                m_q   <= (div_divisor == 32'd0) ? 32'hFFFF_FFFF : div_dividend / div_divisor;
                m_cnt <= 1;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end else begin
            low_run <= low_run + 1;
            m_cnt   <= 0;
        end
    end

    assign div_quotient = (m_cnt >= 35) ? m_q : 32'hDEAD_BEEF;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for resp_valid; drops the accepted client's valid after the accept edge.
    task automatic wait_resp(input int t0, input logic [1:0] drop, output int lat,
                             output int hi, output logic [1:0] rv, output logic [31:0] q);
        lat = -1;
        hi  = 0;
        rv  = '0;
        q   = '0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i == 0) req_valid = req_valid & ~drop;
            if (div_start === 1'b1) hi++;
            if (resp_valid != 2'b00) begin
                lat = cyc - t0;
                rv  = resp_valid;
                q   = resp_quotient;
                break;
            end
        end
        $display("resp owner=%b q=%h latency=%0d start_cycles=%0d", rv, q, lat, hi);
    endtask

    // One isolated job from a single client, checked end to end.
    task automatic job(input string tag, input int client, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_q,
                       input int exp_lat, input int exp_hi);
        logic [1:0]  m;
        int          t0, lat, hi;
        logic [1:0]  rv;
        logic [31:0] q;
        m = 2'b01 << client;
        req_dividend[32*client +: 32] = a;
        req_divisor[32*client +: 32]  = b;
        req_valid = m;
        #1;
        check({tag, "_ready"}, 32'(req_ready), 32'(m));
        t0 = cyc;
        wait_resp(t0, m, lat, hi, rv, q);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_start_cycles"}, 32'(hi), 32'(exp_hi));
        check({tag, "_owner"}, 32'(rv), 32'(m));
        check({tag, "_quot"}, q, exp_q);
        tick();
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_pulse_end"}, 32'(resp_valid), 32'd0);
        check({tag, "_hold"}, resp_quotient, exp_q);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          t0, t1, r1, lat, hi, cnt;
        logic [1:0]  rv, exp_m;
        logic [31:0] q;

        // Reset state, with requests asserted to confirm no grant while held.
        rst_n = 1'b0;
        req_valid = 2'b11;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start", 32'(div_start), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_quot", resp_quotient, 32'd0);
        check("rst_dividend", div_dividend, 32'd0);
        check("rst_divisor", div_divisor, 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        req_valid = 2'b00;
        rst_n = 1'b1;
        tick();

        job("single", 0, 32'd100, 32'd7, 32'd14, 37, 36);
        job("div0", 1, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);

        // Contention from reset: client 0 first, then client 1, 38 cycles apart.
        rst_n = 1'b0;
        req_dividend = {32'd81, 32'd1000};
        req_divisor  = {32'd9, 32'd10};
        req_valid = 2'b11;
        tick();
        check("cont_rst_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        check("cont_ready0", 32'(req_ready), 32'b01);
        t0 = cyc;
        wait_resp(t0, 2'b01, lat, hi, rv, q);
        check("cont_lat0", 32'(lat), 32'd37);
        check("cont_owner0", 32'(rv), 32'b01);
        check("cont_quot0", q, 32'd100);
        r1 = cyc;
        tick();
        check("cont_ready1", 32'(req_ready), 32'b10);
        t1 = cyc;
        wait_resp(t1, 2'b10, lat, hi, rv, q);
        check("cont_owner1", 32'(rv), 32'b10);
        check("cont_quot1", q, 32'd9);
        check("cont_spacing", 32'(cyc - r1), 32'd38);
        tick();

        // Fairness: both held valid for six jobs, grants must alternate.
        req_dividend = {32'd77, 32'd50};
        req_divisor  = {32'd7, 32'd5};
        req_valid = 2'b11;
        #1;
        for (int j = 0; j < 6; j++) begin
            exp_m = (j % 2 == 1) ? 2'b10 : 2'b01;
            check($sformatf("fair_ready%0d", j), 32'(req_ready), 32'(exp_m));
            t0 = cyc;
            wait_resp(t0, 2'b00, lat, hi, rv, q);
            check($sformatf("fair_owner%0d", j), 32'(rv), 32'(exp_m));
            check($sformatf("fair_quot%0d", j), q, (j % 2 == 1) ? 32'd11 : 32'd10);
            tick();
        end
        req_valid = 2'b00;
        check("fair_start_gaps", 32'(gap_viol), 32'd0);

        // Reset at RUN cycle 10 drops the job.
        req_dividend[31:0] = 32'd10;
        req_divisor[31:0]  = 32'd2;
        req_valid = 2'b01;
        #1;
        check("mid_ready", 32'(req_ready), 32'b01);
        tick();
        req_valid = 2'b00;
        check("mid_running", 32'(div_start), 32'd1);
        for (int i = 0; i < 9; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_start", 32'(div_start), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_resp_valid", 32'(resp_valid), 32'd0);
        check("mid_quot", resp_quotient, 32'd0);
        check("mid_dividend", div_dividend, 32'd0);
        check("mid_divisor", div_divisor, 32'd0);
        check("mid_ready_after", 32'(req_ready), 32'd0);
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (resp_valid != 2'b00) cnt++;
        end
        check("mid_no_resp", 32'(cnt), 32'd0);
        job("big", 0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 37, 36);

        // Edge operands.
        job("zero_dividend", 0, 32'd0, 32'd3, 32'd0, 37, 36);
        job("small", 1, 32'd7, 32'd9, 32'd0, 37, 36);
        job("max", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 37, 36);

        check("all_start_gaps", 32'(gap_viol), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
